// File: rtl/z80_io_strobe_sync.sv
// z80_io_strobe_sync
// Bridges the asynchronous TRS-80 Z80 I/O strobes into the clk domain.
// The strobes are synchronised, the bus is sampled once it has settled,
// a single io_access pulse is issued per I/O cycle, and claimed reads
// stall the Z80 with WAIT until the peripheral supplies data (or a
// timeout substitutes IDLE_DATA).

module z80_io_strobe_sync #(
  parameter int         SYNC_STAGES = 2,
  parameter int         SETTLE_CYC  = 2,
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [7:0] IDLE_DATA   = 8'hFF
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       z80_iorq_n,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  input  logic [8:0] z80_a,
  input  logic [7:0] z80_d,
  output logic [8:0] trs_a,
  output logic [7:0] trs_d,
  output logic       trs_in_n,
  output logic       trs_out_n,
  output logic       io_access,
  input  logic       rd_claim,
  input  logic [7:0] rd_data,
  input  logic       rd_rdy,
  output logic       wait_n,
  output logic       dbus_oe,
  output logic [7:0] dbus_dout,
  output logic       timeout_err
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_ACCESS   = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DRIVE    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t                 state_r;
  logic [7:0]             cnt_r;
  logic                   is_rd_r;
  logic [SYNC_STAGES-1:0] iorq_sync_r;
  logic [SYNC_STAGES-1:0] rd_sync_r;
  logic [SYNC_STAGES-1:0] wr_sync_r;

  // Active-high views of the synchronised strobes.
  logic iorq_s;
  logic rd_s;
  logic wr_s;
  logic valid_s;
  logic abort_s;

  // Strobe synchronisers; idle (high) after reset so no phantom cycle starts.
  always_ff @(posedge clk) begin
    if (srst) begin
      iorq_sync_r <= {SYNC_STAGES{1'b1}};
      rd_sync_r   <= {SYNC_STAGES{1'b1}};
      wr_sync_r   <= {SYNC_STAGES{1'b1}};
    end else begin
      iorq_sync_r <= {iorq_sync_r[SYNC_STAGES-2:0], z80_iorq_n};
      rd_sync_r   <= {rd_sync_r[SYNC_STAGES-2:0], z80_rd_n};
      wr_sync_r   <= {wr_sync_r[SYNC_STAGES-2:0], z80_wr_n};
    end
  end

  // Decode the synchronised strobes into cycle-valid and cycle-abort conditions.
  always_comb begin
    iorq_s  = ~iorq_sync_r[SYNC_STAGES-1];
    rd_s    = ~rd_sync_r[SYNC_STAGES-1];
    wr_s    = ~wr_sync_r[SYNC_STAGES-1];
    valid_s = iorq_s & (rd_s ^ wr_s);
    if (!iorq_s) begin
      abort_s = 1'b1;
    end else if (is_rd_r) begin
      abort_s = ~rd_s;
    end else begin
      abort_s = ~wr_s;
    end
  end

  // Cycle sequencer with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      is_rd_r     <= 1'b0;
      trs_a       <= 9'd0;
      trs_d       <= 8'd0;
      trs_in_n    <= 1'b1;
      trs_out_n   <= 1'b1;
      io_access   <= 1'b0;
      wait_n      <= 1'b1;
      dbus_oe     <= 1'b0;
      dbus_dout   <= IDLE_DATA;
      timeout_err <= 1'b0;
    end else begin
      io_access <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iorq_s) begin
            if (valid_s) begin
              state_r <= ST_SETTLE;
              cnt_r   <= 8'd0;
              is_rd_r <= rd_s;
            end else begin
              // INTA or both strobes low: not an I/O transfer, just wait it out.
              state_r <= ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else if (cnt_r == SETTLE_LAST) begin
            trs_a <= z80_a;
            if (!is_rd_r) begin
              trs_d <= z80_d;
            end
            trs_in_n  <= ~is_rd_r;
            trs_out_n <= is_rd_r;
            io_access <= 1'b1;
            state_r   <= ST_ACCESS;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_ACCESS: begin
          if (abort_s) begin
            trs_in_n  <= 1'b1;
            trs_out_n <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (!is_rd_r) begin
            state_r <= ST_DONE;
          end else if (rd_claim) begin
            if (rd_rdy) begin
              dbus_dout <= rd_data;
              dbus_oe   <= 1'b1;
              state_r   <= ST_DRIVE;
            end else begin
              wait_n  <= 1'b0;
              cnt_r   <= 8'd0;
              state_r <= ST_WAIT_RDY;
            end
          end else begin
            // Nobody claimed the read: leave the board data bus undriven.
            state_r <= ST_DONE;
          end
        end
        ST_WAIT_RDY: begin
          if (abort_s) begin
            wait_n    <= 1'b1;
            dbus_oe   <= 1'b0;
            trs_in_n  <= 1'b1;
            trs_out_n <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (rd_rdy) begin
            // Data arriving on the timeout cycle still wins.
            dbus_dout <= rd_data;
            dbus_oe   <= 1'b1;
            wait_n    <= 1'b1;
            state_r   <= ST_DRIVE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            dbus_dout   <= IDLE_DATA;
            timeout_err <= 1'b1;
            dbus_oe     <= 1'b1;
            wait_n      <= 1'b1;
            state_r     <= ST_DRIVE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_DRIVE: begin
          if (!iorq_s || !rd_s) begin
            dbus_oe   <= 1'b0;
            trs_in_n  <= 1'b1;
            trs_out_n <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!iorq_s) begin
            trs_in_n  <= 1'b1;
            trs_out_n <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          wait_n    <= 1'b1;
          dbus_oe   <= 1'b0;
          trs_in_n  <= 1'b1;
          trs_out_n <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_strobe_sync.sv
// Self-checking bench for z80_io_strobe_sync: bus transactions push their
// expected access/read results into queues that a negedge monitor pops.

module tb_z80_io_strobe_sync;

  logic       clk = 1'b0;
  logic       srst;
  logic       z80_iorq_n, z80_rd_n, z80_wr_n;
  logic [8:0] z80_a;
  logic [7:0] z80_d;
  logic [8:0] trs_a;
  logic [7:0] trs_d;
  logic       trs_in_n, trs_out_n, io_access;
  logic       rd_claim, rd_rdy;
  logic [7:0] rd_data;
  logic       wait_n, dbus_oe;
  logic [7:0] dbus_dout;
  logic       timeout_err;

  z80_io_strobe_sync #(
    .SYNC_STAGES(2), .SETTLE_CYC(2), .TIMEOUT_CYC(16), .IDLE_DATA(8'hFF)
  ) dut (
    .clk(clk), .srst(srst),
    .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_a(z80_a), .z80_d(z80_d),
    .trs_a(trs_a), .trs_d(trs_d), .trs_in_n(trs_in_n), .trs_out_n(trs_out_n),
    .io_access(io_access),
    .rd_claim(rd_claim), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .wait_n(wait_n), .dbus_oe(dbus_oe), .dbus_dout(dbus_dout),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    bit         rd;
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] rd_q[$];
  acc_t       mon_e;
  logic [7:0] mon_d;
  logic       oe_prev = 1'b0;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every io_access and every dbus_oe rise consumes an expectation.
  always @(negedge clk) begin
    if (!srst) begin
      if (io_access) begin
        if (acc_q.size() == 0) begin
          check("spurious_access", 32'd1, 32'd0);
        end else begin
          mon_e = acc_q.pop_front();
          check("trs_a", 32'(trs_a), 32'(mon_e.a));
          if (!mon_e.rd) check("trs_d", 32'(trs_d), 32'(mon_e.d));
          check("trs_in_n", 32'(trs_in_n), 32'(!mon_e.rd));
          check("trs_out_n", 32'(trs_out_n), 32'(mon_e.rd));
        end
      end
      if (dbus_oe && !oe_prev) begin
        if (rd_q.size() == 0) begin
          check("spurious_drive", 32'd1, 32'd0);
        end else begin
          mon_d = rd_q.pop_front();
          check("dbus_dout", 32'(dbus_dout), 32'(mon_d));
        end
      end
    end
    oe_prev = dbus_oe;
  end

  task automatic idle_bus();
    z80_iorq_n = 1'b1;
    z80_rd_n   = 1'b1;
    z80_wr_n   = 1'b1;
  endtask

  task automatic release_and_wait(input int n);
    @(negedge clk);
    idle_bus();
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits (bounded) for the negedge where io_access is seen high.
  task automatic wait_access(input string tag);
    bit seen;
    int i;
    seen = 1'b0;
    i = 0;
    while (!seen && i < 30) begin
      @(negedge clk);
      if (io_access) seen = 1'b1;
      i++;
    end
    if (!seen) check(tag, 32'd0, 32'd1);
  endtask

  task automatic start_cycle(input logic [8:0] a, input logic [7:0] d, input bit rd);
    acc_t e;
    @(negedge clk);
    z80_a = a;
    z80_d = d;
    e.a = a;
    e.d = d;
    e.rd = rd;
    acc_q.push_back(e);
    z80_rd_n   = ~rd;
    z80_wr_n   = rd;
    z80_iorq_n = 1'b0;
  endtask

  int first_k, n_acc, n_low, n_oe;

  initial begin
    idle_bus();
    z80_a = 9'd0; z80_d = 8'd0;
    rd_claim = 1'b0; rd_rdy = 1'b0; rd_data = 8'h00;
    srst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_trs_a", 32'(trs_a), 32'd0);
    check("rst_trs_d", 32'(trs_d), 32'd0);
    check("rst_trs_in_n", 32'(trs_in_n), 32'd1);
    check("rst_trs_out_n", 32'(trs_out_n), 32'd1);
    check("rst_io_access", 32'(io_access), 32'd0);
    check("rst_wait_n", 32'(wait_n), 32'd1);
    check("rst_dbus_oe", 32'(dbus_oe), 32'd0);
    check("rst_dbus_dout", 32'(dbus_dout), 32'hFF);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    srst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x5A to port 0x080: io_access exactly once, on edge 5.
    start_cycle(9'h080, 8'h5A, 1'b0);
    first_k = 0; n_acc = 0; n_low = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (io_access) begin
        n_acc++;
        if (first_k == 0) first_k = k;
      end
      if (!wait_n) n_low++;
    end
    check("wr_latency", 32'(first_k), 32'd5);
    check("wr_access_cnt", 32'(n_acc), 32'd1);
    check("wr_wait_low", 32'(n_low), 32'd0);
    check("wr_out_n_held", 32'(trs_out_n), 32'd0);
    release_and_wait(6);
    check("wr_out_n_release", 32'(trs_out_n), 32'd1);

    // Claimed read of 0x082, data ready three cycles after ACCESS.
    rd_claim = 1'b1;
    start_cycle(9'h082, 8'h00, 1'b1);
    rd_q.push_back(8'hC3);
    wait_access("rd_access_wait");
    n_low = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!wait_n) n_low++;
      if (k == 3) begin
        rd_rdy = 1'b1;
        rd_data = 8'hC3;
      end else begin
        rd_rdy = 1'b0;
      end
    end
    check("rd_wait_low", 32'(n_low), 32'd3);
    check("rd_oe_held", 32'(dbus_oe), 32'd1);
    check("rd_dout_held", 32'(dbus_dout), 32'hC3);
    release_and_wait(6);
    check("rd_oe_release", 32'(dbus_oe), 32'd0);
    check("rd_in_n_release", 32'(trs_in_n), 32'd1);

    // Claimed read with no data: 16-cycle WAIT, then IDLE_DATA and sticky error.
    start_cycle(9'h084, 8'h00, 1'b1);
    rd_q.push_back(8'hFF);
    wait_access("to_access_wait");
    n_low = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (!wait_n) n_low++;
    end
    check("to_wait_low", 32'(n_low), 32'd16);
    check("to_dout", 32'(dbus_dout), 32'hFF);
    check("to_oe", 32'(dbus_oe), 32'd1);
    check("to_err", 32'(timeout_err), 32'd1);
    release_and_wait(6);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    check("to_oe_release", 32'(dbus_oe), 32'd0);

    // Unclaimed read of 0x0FE: one access, no WAIT, bus never driven.
    rd_claim = 1'b0;
    start_cycle(9'h0FE, 8'h00, 1'b1);
    n_acc = 0; n_low = 0; n_oe = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (io_access) n_acc++;
      if (!wait_n) n_low++;
      if (dbus_oe) n_oe++;
    end
    check("unc_access_cnt", 32'(n_acc), 32'd1);
    check("unc_wait_low", 32'(n_low), 32'd0);
    check("unc_oe_cnt", 32'(n_oe), 32'd0);
    release_and_wait(6);

    // INTA (IORQ alone) and IORQ with both strobes: no access at all.
    @(negedge clk);
    z80_iorq_n = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (io_access) n_acc++;
    end
    check("inta_access_cnt", 32'(n_acc), 32'd0);
    release_and_wait(6);
    @(negedge clk);
    z80_iorq_n = 1'b0; z80_rd_n = 1'b0; z80_wr_n = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (io_access) n_acc++;
    end
    check("both_access_cnt", 32'(n_acc), 32'd0);
    check("both_in_n", 32'(trs_in_n), 32'd1);
    check("both_out_n", 32'(trs_out_n), 32'd1);
    release_and_wait(6);

    // srst while stalled in WAIT_RDY, then a normal write.
    rd_claim = 1'b1;
    start_cycle(9'h086, 8'h00, 1'b1);
    wait_access("rst_access_wait");
    repeat (3) @(negedge clk);
    check("pre_rst_wait_low", 32'(wait_n), 32'd0);
    srst = 1'b1;
    idle_bus();
    @(negedge clk);
    check("srst_wait_n", 32'(wait_n), 32'd1);
    check("srst_oe", 32'(dbus_oe), 32'd0);
    check("srst_err", 32'(timeout_err), 32'd0);
    check("srst_in_n", 32'(trs_in_n), 32'd1);
    srst = 1'b0;
    repeat (3) @(negedge clk);
    rd_claim = 1'b0;
    start_cycle(9'h081, 8'h33, 1'b0);
    first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (io_access && first_k == 0) first_k = k;
    end
    check("post_rst_latency", 32'(first_k), 32'd5);
    release_and_wait(6);

    check("acc_q_empty", 32'(acc_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
